// File: rtl/option_streamer.sv
// Option streamer: buffers header/option entries in a circular FIFO, then streams them to a
// solver, recycling kept options. Define STREAMER_PASS_CNT_EN to add the pass_cnt output.
module option_streamer #(
  parameter int unsigned SIZE  = 3,
  parameter int unsigned DEPTH = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            load_header,
  input  logic [SIZE-1:0] load_data,
  input  logic            load_done,
  output logic            started,
  output logic [SIZE-1:0] option,
  output logic            valid_op,
  input  logic            put_back_to_FIFO,
  input  logic            solved,
  output logic [6:0]      options_amnt [2*SIZE],
`ifdef STREAMER_PASS_CNT_EN
  output logic [15:0]     pass_cnt,
`endif
  output logic            done
);

  localparam int unsigned Lines   = 2 * SIZE;
  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam logic [PtrW:0] FullCnt = DEPTH[PtrW:0];
  localparam logic [6:0]  AmntMax = 7'h7f;

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

  typedef struct packed {
    logic            hdr;
    logic [SIZE-1:0] data;
  } entry_t;

  function automatic logic line_ok(input logic [SIZE-1:0] l);
    return 32'(l) < Lines;
  endfunction

  state_e          state_q, state_d;
  entry_t          mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]   cnt_q, cnt_d;
  logic [SIZE-1:0] cur_line_q, cur_line_d;
  logic            cur_vld_q, cur_vld_d;
  logic [SIZE-1:0] pop_line_q, pop_line_d;
  logic [SIZE-1:0] iss_line_q, iss_line_d;
  logic            iss_hdr_q, iss_hdr_d;
  logic [SIZE-1:0] option_q, option_d;
  logic            valid_q, valid_d;
  logic            started_q, started_d;
  logic            first_q, first_d;
  logic            ready_en_q;
  logic [6:0]      amnt_q [Lines];
  logic [6:0]      amnt_d [Lines];
`ifdef STREAMER_PASS_CNT_EN
  logic [15:0]     pass_cnt_q, pass_cnt_d;
`endif

  logic            accept;
  logic            push, pop;
  entry_t          push_data;
  entry_t          head;
  logic            repush;
  logic            drop_opt;
  logic [6:0]      hdr_cnt;

  // ready_en_q keeps load_ready low while reset is asserted and up to the first clock edge.
  assign load_ready = ready_en_q && (state_q == StIdle || state_q == StLoad) &&
                      (cnt_q != FullCnt);
  assign accept     = load_valid && load_ready;
  assign head       = mem_q[rptr_q];
  assign repush     = valid_q && (iss_hdr_q || put_back_to_FIFO);
  assign drop_opt   = valid_q && !iss_hdr_q && !put_back_to_FIFO;

  always_comb begin
    state_d    = state_q;
    cur_line_d = cur_line_q;
    cur_vld_d  = cur_vld_q;
    pop_line_d = pop_line_q;
    iss_line_d = iss_line_q;
    iss_hdr_d  = iss_hdr_q;
    option_d   = option_q;
    valid_d    = 1'b0;
    started_d  = 1'b0;
    first_d    = first_q;
    amnt_d     = amnt_q;
    push       = 1'b0;
    push_data  = '0;
    pop        = 1'b0;
    hdr_cnt    = '0;
`ifdef STREAMER_PASS_CNT_EN
    pass_cnt_d = pass_cnt_q;
`endif

    unique case (state_q)
      StIdle, StLoad: begin
        if (accept) begin
          if (load_header) begin
            push       = 1'b1;
            push_data  = {1'b1, load_data};
            cur_line_d = load_data;
            cur_vld_d  = 1'b1;
          end else if (cur_vld_q) begin
            // Options arriving before any header have no line and are dropped.
            push      = 1'b1;
            push_data = {1'b0, load_data};
            if (line_ok(cur_line_q) && amnt_q[cur_line_q] != AmntMax) begin
              amnt_d[cur_line_q] = amnt_q[cur_line_q] + 7'd1;
            end
          end
        end
        if (state_q == StIdle) begin
          if (load_done) begin
            state_d = StDone;
          end else if (accept) begin
            state_d = StLoad;
          end
        end else if (load_done) begin
          state_d = StStream;
          first_d = 1'b1;
        end
      end

      StStream: begin
        if (drop_opt && line_ok(iss_line_q) && amnt_q[iss_line_q] != '0) begin
          amnt_d[iss_line_q] = amnt_q[iss_line_q] - 7'd1;
        end
        if (repush) begin
          push      = 1'b1;
          push_data = {iss_hdr_q, option_q};
        end
        if (solved) begin
          state_d = StDone;
        end else if (cnt_q != '0) begin
          pop = 1'b1;
          if (head.hdr) begin
            pop_line_d = head.data;
            // amnt_d already reflects the option being retired this cycle.
            if (line_ok(head.data)) begin
              hdr_cnt = amnt_d[head.data];
            end
          end
          if (!head.hdr || hdr_cnt != '0) begin
            valid_d    = 1'b1;
            started_d  = first_q;
            first_d    = 1'b0;
            option_d   = head.data;
            iss_hdr_d  = head.hdr;
            iss_line_d = head.hdr ? head.data : pop_line_q;
`ifdef STREAMER_PASS_CNT_EN
            if (head.hdr && head.data == '0) begin
              pass_cnt_d = pass_cnt_q + 16'd1;
            end
`endif
          end
        end else if (!repush) begin
          state_d = StDone;
        end
      end

      default: ;
    endcase
  end

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      cur_line_q <= '0;
      cur_vld_q  <= 1'b0;
      pop_line_q <= '0;
      iss_line_q <= '0;
      iss_hdr_q  <= 1'b0;
      option_q   <= '0;
      valid_q    <= 1'b0;
      started_q  <= 1'b0;
      first_q    <= 1'b0;
      ready_en_q <= 1'b0;
      amnt_q     <= '{default: '0};
`ifdef STREAMER_PASS_CNT_EN
      pass_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      cur_line_q <= cur_line_d;
      cur_vld_q  <= cur_vld_d;
      pop_line_q <= pop_line_d;
      iss_line_q <= iss_line_d;
      iss_hdr_q  <= iss_hdr_d;
      option_q   <= option_d;
      valid_q    <= valid_d;
      started_q  <= started_d;
      first_q    <= first_d;
      ready_en_q <= 1'b1;
      amnt_q     <= amnt_d;
`ifdef STREAMER_PASS_CNT_EN
      pass_cnt_q <= pass_cnt_d;
`endif
    end
  end

  assign valid_op     = valid_q;
  assign started      = started_q;
  assign option       = option_q;
  assign done         = (state_q == StDone);
  assign options_amnt = amnt_q;
`ifdef STREAMER_PASS_CNT_EN
  assign pass_cnt     = pass_cnt_q;
`endif

endmodule
